// File: rtl/hps_reset_event_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// hps_rst_pkg
// Shared types and constants for the HPS reset-request / STM event front end.
//   req_e       : request kind, also the encoding of the last_req output
//   fsm_e       : request FSM states
//   SYNC_STAGES : flip-flops in every asynchronous-input synchroniser
//   pick_req()  : fixed priority cold > warm > debug over press strobes
// ---------------------------------------------------------------------------
package hps_rst_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    REQ_NONE  = 2'd0,
    REQ_COLD  = 2'd1,
    REQ_WARM  = 2'd2,
    REQ_DEBUG = 2'd3
  } req_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ASSERT,
    ST_WAIT_LOW,
    ST_WAIT_HIGH,
    ST_HOLDOFF
  } fsm_e;

  // press[0] cold, press[1] warm, press[2] debug
  function automatic req_e pick_req(input logic [2:0] press);
    if (press[0])      return REQ_COLD;
    else if (press[1]) return REQ_WARM;
    else if (press[2]) return REQ_DEBUG;
    else               return REQ_NONE;
  endfunction

endpackage

// File: rtl/hps_reset_event_ctrl_if.sv
// ---------------------------------------------------------------------------
// hps_reset_event_ctrl_if
// Fabric <-> HPS reset/event signals of the soc_system platform.
//   f2h_*_reset_req_n : active-low reset requests, fabric -> HPS
//   stm_hwevents      : single-cycle STM hardware events, fabric -> HPS
//   h2f_reset_n       : HPS -> fabric reset (asynchronous to the fabric clock)
// Modports: master = fabric controller, slave = HPS side.
// ---------------------------------------------------------------------------
interface hps_reset_event_ctrl_if #(
  parameter int N_EVENTS = 28
);
  logic                f2h_cold_reset_req_n;
  logic                f2h_warm_reset_req_n;
  logic                f2h_debug_reset_req_n;
  logic [N_EVENTS-1:0] stm_hwevents;
  logic                h2f_reset_n;

  modport master (
    output f2h_cold_reset_req_n, f2h_warm_reset_req_n, f2h_debug_reset_req_n,
    output stm_hwevents,
    input  h2f_reset_n
  );

  modport slave (
    input  f2h_cold_reset_req_n, f2h_warm_reset_req_n, f2h_debug_reset_req_n,
    input  stm_hwevents,
    output h2f_reset_n
  );
endinterface

// File: rtl/hps_reset_event_ctrl_key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
// One push-button: synchroniser, stable-level debounce counter, press strobe.
//   clk, rst_n : clock, asynchronous active-low reset
//   key_n      : raw asynchronous active-low button
//   press      : one-cycle strobe on a debounced 1->0 transition
//   level      : debounced level (only with HPS_RST_LONG_PRESS_EN)
// A new level is accepted after DEBOUNCE_CYCLES consecutive cycles in which
// the synced input differs from the current debounced level.
// ---------------------------------------------------------------------------
module key_debounce
  import hps_rst_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
`ifdef HPS_RST_LONG_PRESS_EN
  ,
  output logic level
`endif
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic                   deb_q;
  logic [CW-1:0]          cnt_q;

  assign synced = sync_q[SYNC_STAGES-1];

  // NOTE: sequential state uses <= so every flop samples pre-edge values;
  // a blocking = would collapse the synchroniser stages into one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      deb_q  <= 1'b1;
      cnt_q  <= '0;
      press  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], key_n};
      press  <= 1'b0;
      if (synced == deb_q) begin
        cnt_q <= '0;
      end else if (cnt_q >= CNT_LAST) begin
        deb_q <= synced;
        cnt_q <= '0;
        // Differing levels with deb_q=1 means a press; releases stay silent.
        press <= deb_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

`ifdef HPS_RST_LONG_PRESS_EN
  assign level = deb_q;
`endif

endmodule

// File: rtl/hps_reset_event_ctrl.sv
// ---------------------------------------------------------------------------
// hps_reset_event_ctrl
// FPGA front end for the HPS reset-request and STM hardware-event inputs.
//   clk_clk       : system clock
//   reset_reset_n : asynchronous active-low reset; must never be derived from
//                   h2f_reset_n, or a warm reset would wipe this block mid-cycle
//   key_n[2:0]    : raw active-low buttons, [0] cold, [1] warm, [2] debug
//   hw_event_in   : asynchronous fabric event levels
//   hps           : master side of hps_reset_event_ctrl_if (req_n, STM, h2f)
//   busy          : request FSM not in IDLE
//   last_req      : last request issued (req_e encoding)
// Optional: HPS_RST_LONG_PRESS_EN escalates a long warm-key hold to a cold
// request once the FSM is back in IDLE.
// ---------------------------------------------------------------------------
module hps_reset_event_ctrl
  import hps_rst_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int PULSE_CYCLES    = 16,
  parameter int WAIT_TIMEOUT    = 5000000,
  parameter int HOLDOFF_CYCLES  = 1000,
  parameter int N_EVENTS        = 28
`ifdef HPS_RST_LONG_PRESS_EN
  ,
  parameter int LONG_CYCLES     = 100000000
`endif
) (
  input  logic                   clk_clk,
  input  logic                   reset_reset_n,
  input  logic [2:0]             key_n,
  input  logic [N_EVENTS-1:0]    hw_event_in,
  hps_reset_event_ctrl_if.master hps,
  output logic                   busy,
  output logic [1:0]             last_req
);

  localparam int             PCW        = $clog2(PULSE_CYCLES + 1);
  localparam int             TCW        = $clog2(WAIT_TIMEOUT + 1);
  localparam int             HCW        = $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [PCW-1:0] PULSE_LAST = PCW'(PULSE_CYCLES - 1);
  localparam logic [PCW-1:0] PULSE_MAX  = PCW'(PULSE_CYCLES);
  localparam logic [TCW-1:0] TMO_LAST   = TCW'(WAIT_TIMEOUT - 1);
  localparam logic [TCW-1:0] TMO_MAX    = TCW'(WAIT_TIMEOUT);
  localparam logic [HCW-1:0] HOLD_LAST  = HCW'(HOLDOFF_CYCLES - 1);
  localparam logic [HCW-1:0] HOLD_MAX   = HCW'(HOLDOFF_CYCLES);

  logic [2:0]             press;
  logic [SYNC_STAGES-1:0] h2f_sync_q;
  logic                   h2f_synced;
  fsm_e                   state_q, state_d;
  req_e                   last_q, sel_d;
  logic [2:0]             req_n_q, req_n_d;
  logic [PCW-1:0]         pulse_q;
  logic [TCW-1:0]         tmo_q;
  logic [HCW-1:0]         hold_q;

`ifdef HPS_RST_LONG_PRESS_EN
  logic [2:0] key_level;
`endif

  for (genvar k = 0; k < 3; k++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
      .clk   (clk_clk),
      .rst_n (reset_reset_n),
      .key_n (key_n[k]),
      .press (press[k])
`ifdef HPS_RST_LONG_PRESS_EN
      ,
      .level (key_level[k])
`endif
    );
  end

  assign h2f_synced = h2f_sync_q[SYNC_STAGES-1];

`ifdef HPS_RST_LONG_PRESS_EN
  localparam int             LCW       = $clog2(LONG_CYCLES + 1);
  localparam logic [LCW-1:0] LONG_LAST = LCW'(LONG_CYCLES - 1);
  localparam logic [LCW-1:0] LONG_MAX  = LCW'(LONG_CYCLES);

  logic [LCW-1:0] long_q;
  logic           long_window;
  logic           long_fire;

  // The hold is measured only while IDLE/HOLDOFF; it saturates at
  // LONG_CYCLES, so a threshold crossing that lands in HOLDOFF is lost.
  assign long_window = (state_q == ST_IDLE) || (state_q == ST_HOLDOFF);
  assign long_fire   = !key_level[1] && long_window && (long_q == LONG_LAST);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n)                      long_q <= '0;
    else if (key_level[1])                   long_q <= '0;
    else if (long_window && long_q != LONG_MAX) long_q <= long_q + 1'b1;
  end
`endif

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one
    // unassigned; a missed path in always_comb would infer a latch.
    state_d = state_q;
    sel_d   = last_q;
    req_n_d = 3'b111;
    unique case (state_q)
      ST_IDLE: begin
        if (|press) begin
          state_d = ST_ASSERT;
          sel_d   = pick_req(press);
        end
`ifdef HPS_RST_LONG_PRESS_EN
        else if (long_fire) begin
          state_d = ST_ASSERT;
          sel_d   = REQ_COLD;
        end
`endif
      end
      ST_ASSERT: begin
        if (pulse_q == PULSE_LAST)
          state_d = (last_q == REQ_DEBUG) ? ST_HOLDOFF : ST_WAIT_LOW;
      end
      ST_WAIT_LOW: begin
        if (tmo_q == TMO_LAST) state_d = ST_HOLDOFF;
        else if (!h2f_synced)  state_d = ST_WAIT_HIGH;
      end
      ST_WAIT_HIGH: begin
        if (tmo_q == TMO_LAST || h2f_synced) state_d = ST_HOLDOFF;
      end
      ST_HOLDOFF: begin
        if (hold_q == HOLD_LAST) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Requests are registered from the next state, so the pulse covers
    // exactly the cycles the FSM spends in ASSERT.
    if (state_d == ST_ASSERT) begin
      case (sel_d)
        REQ_COLD:  req_n_d[0] = 1'b0;
        REQ_WARM:  req_n_d[1] = 1'b0;
        REQ_DEBUG: req_n_d[2] = 1'b0;
        default:   req_n_d    = 3'b111;
      endcase
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q    <= ST_IDLE;
      last_q     <= REQ_NONE;
      req_n_q    <= 3'b111;
      pulse_q    <= '0;
      tmo_q      <= '0;
      hold_q     <= '0;
      h2f_sync_q <= '1;
    end else begin
      state_q    <= state_d;
      last_q     <= sel_d;
      req_n_q    <= req_n_d;
      h2f_sync_q <= {h2f_sync_q[SYNC_STAGES-2:0], hps.h2f_reset_n};
      // Each counter clears outside its state(s) and saturates inside; the
      // timeout spans WAIT_LOW and WAIT_HIGH, so it clears only on entry.
      pulse_q <= (state_q != ST_ASSERT) ? '0 :
                 (pulse_q == PULSE_MAX) ? pulse_q : pulse_q + 1'b1;
      tmo_q   <= (state_q != ST_WAIT_LOW && state_q != ST_WAIT_HIGH) ? '0 :
                 (tmo_q == TMO_MAX) ? tmo_q : tmo_q + 1'b1;
      hold_q  <= (state_q != ST_HOLDOFF) ? '0 :
                 (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
    end
  end

  // STM events: 2-stage sync, then a registered rising-edge detect.
  logic [N_EVENTS-1:0] ev_sync_q [SYNC_STAGES];
  logic [N_EVENTS-1:0] ev_d_q;
  logic [N_EVENTS-1:0] stm_q;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      // NOTE: this array is a flop pipeline, not RAM, so resetting it is
      // intended and keeps spurious pulses out of the first cycles.
      for (int s = 0; s < SYNC_STAGES; s++) ev_sync_q[s] <= '0;
      ev_d_q <= '0;
      stm_q  <= '0;
    end else begin
      ev_sync_q[0] <= hw_event_in;
      for (int s = 1; s < SYNC_STAGES; s++) ev_sync_q[s] <= ev_sync_q[s-1];
      ev_d_q <= ev_sync_q[SYNC_STAGES-1];
      stm_q  <= ev_sync_q[SYNC_STAGES-1] & ~ev_d_q;
    end
  end

  assign hps.f2h_cold_reset_req_n  = req_n_q[0];
  assign hps.f2h_warm_reset_req_n  = req_n_q[1];
  assign hps.f2h_debug_reset_req_n = req_n_q[2];
  assign hps.stm_hwevents          = stm_q;
  assign busy                      = (state_q != ST_IDLE);
  assign last_req                  = last_q;

endmodule

// File: tb/tb_hps_reset_event_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hps_reset_event_ctrl
// Directed bench for hps_reset_event_ctrl with DEBOUNCE_CYCLES=8,
// PULSE_CYCLES=4, WAIT_TIMEOUT=64, HOLDOFF_CYCLES=10 (LONG_CYCLES=200 when
// HPS_RST_LONG_PRESS_EN is defined). Inputs change 1 time unit after a rising
// edge; request lines are tallied by a monitor on the falling edge.
// ---------------------------------------------------------------------------
module tb_hps_reset_event_ctrl;
  import hps_rst_pkg::*;

  localparam int N_EVENTS = 28;

  logic                clk_clk       = 1'b0;
  logic                reset_reset_n = 1'b0;
  logic [2:0]          key_n         = 3'b111;
  logic [N_EVENTS-1:0] hw_event_in   = '0;
  logic                busy;
  logic [1:0]          last_req;

  hps_reset_event_ctrl_if #(.N_EVENTS(N_EVENTS)) hps ();

  hps_reset_event_ctrl #(
    .DEBOUNCE_CYCLES (8),
    .PULSE_CYCLES    (4),
    .WAIT_TIMEOUT    (64),
    .HOLDOFF_CYCLES  (10),
    .N_EVENTS        (N_EVENTS)
`ifdef HPS_RST_LONG_PRESS_EN
    ,
    .LONG_CYCLES     (200)
`endif
  ) u_dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .key_n         (key_n),
    .hw_event_in   (hw_event_in),
    .hps           (hps.master),
    .busy          (busy),
    .last_req      (last_req)
  );

  always #5 clk_clk = ~clk_clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] reqs();
    return {hps.f2h_debug_reset_req_n, hps.f2h_warm_reset_req_n, hps.f2h_cold_reset_req_n};
  endfunction

  // Request monitor: falling edges, low cycles, cycles with >1 request low.
  int         falls [3] = '{0, 0, 0};
  int         lows  [3] = '{0, 0, 0};
  int         overlap   = 0;
  logic [2:0] prev_req  = 3'b111;

  always @(negedge clk_clk) begin
    logic [2:0] cur;
    cur = reqs();
    for (int k = 0; k < 3; k++) begin
      if (prev_req[k] && !cur[k]) falls[k]++;
      if (!cur[k])                lows[k]++;
    end
    if ($countones(~cur) > 1) overlap++;
    prev_req = cur;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_clk);
    #1;
  endtask

  task automatic wait_req(input int k, input logic lvl, input string tag);
    logic [2:0] r;
    int         n;
    n = 0;
    r = reqs();
    while (r[k] !== lvl && n < 40) begin
      cyc(1);
      n++;
      r = reqs();
    end
    check(tag, r[k], lvl);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 200) begin
      cyc(1);
      n++;
    end
    check(tag, busy, 1'b0);
  endtask

  // Cycles from now until busy drops (bounded).
  task automatic cycles_to_idle(output int n);
    n = 0;
    while (busy !== 1'b0 && n < 200) begin
      cyc(1);
      n++;
    end
  endtask

  initial begin
    int f0 [3];
    int l0 [3];
    int n;

    hps.h2f_reset_n = 1'b1;

    // Reset state
    cyc(3);
    check("rst_req_n",    reqs(), 3'b111);
    check("rst_stm",      hps.stm_hwevents, '0);
    check("rst_busy",     busy, 1'b0);
    check("rst_last_req", last_req, REQ_NONE);
    reset_reset_n = 1'b1;
    cyc(2);

    // Warm press with two 3-cycle glitches, then stable low 20 cycles
    f0 = falls;
    l0 = lows;
    for (int g = 0; g < 2; g++) begin
      key_n[1] = 1'b0; cyc(3);
      key_n[1] = 1'b1; cyc(3);
    end
    check("glitch_no_busy", busy, 1'b0);
    key_n[1] = 1'b0;
    cyc(20);
    key_n[1] = 1'b1;
    check("warm_falls",      falls[1] - f0[1], 1);
    check("warm_low_cycles", lows[1] - l0[1], 4);
    check("warm_no_cold",    falls[0] - f0[0], 0);
    check("warm_no_debug",   falls[2] - f0[2], 0);
    check("warm_last_req",   last_req, REQ_WARM);
    wait_idle("warm_idle");
    cyc(20);

    // Cold request with an HPS reset cycle: h2f low 5 cycles, 10 after pulse.
    // Idle follows 13 cycles after the raw rise: 2 sync + 1 + 10 holdoff.
    key_n[0] = 1'b0;
    wait_req(0, 1'b0, "cold_h2f_low_seen");
    wait_req(0, 1'b1, "cold_h2f_rise_seen");
    key_n[0] = 1'b1;
    check("cold_h2f_last_req", last_req, REQ_COLD);
    cyc(10);
    hps.h2f_reset_n = 1'b0;
    cyc(5);
    check("cold_h2f_busy_in_reset", busy, 1'b1);
    hps.h2f_reset_n = 1'b1;
    cycles_to_idle(n);
    check("cold_h2f_idle_delay", n, 13);
    cyc(20);

    // Cold request with h2f held high: 64 cycles WAIT_LOW + 10 HOLDOFF
    l0 = lows;
    key_n[0] = 1'b0;
    wait_req(0, 1'b0, "cold_tmo_low_seen");
    wait_req(0, 1'b1, "cold_tmo_rise_seen");
    key_n[0] = 1'b1;
    check("cold_tmo_low_cycles", lows[0] - l0[0], 4);
    cycles_to_idle(n);
    check("cold_tmo_idle_delay", n, 74);
    cyc(20);

    // Cold + debug in the same cycle; then debug pressed during HOLDOFF
    f0 = falls;
    key_n = 3'b010;
    wait_req(0, 1'b0, "both_cold_low_seen");
    check("both_debug_high", hps.f2h_debug_reset_req_n, 1'b1);
    wait_req(0, 1'b1, "both_cold_rise_seen");
    key_n = 3'b111;
    // Strobe lands 10 cycles after the drive: cycle 68 of WAIT_LOW+HOLDOFF
    cyc(58);
    key_n[2] = 1'b0;
    wait_idle("both_idle");
    cyc(10);
    check("holdoff_press_dropped", busy, 1'b0);
    check("both_cold_falls",  falls[0] - f0[0], 1);
    check("both_debug_falls", falls[2] - f0[2], 0);
    check("both_last_req",    last_req, REQ_COLD);
    key_n[2] = 1'b1;
    cyc(20);

    // STM event: held-high input gives one pulse 3 cycles later
    hw_event_in = 28'h0000005;
    cyc(1); check("stm_c1", hps.stm_hwevents, 28'h0);
    cyc(1); check("stm_c2", hps.stm_hwevents, 28'h0);
    cyc(1); check("stm_c3", hps.stm_hwevents, 28'h0000005);
    cyc(1); check("stm_c4", hps.stm_hwevents, 28'h0);
    cyc(3); check("stm_held", hps.stm_hwevents, 28'h0);

    // Reset mid-ASSERT releases the request at once
    key_n[2] = 1'b0;
    wait_req(2, 1'b0, "rst_mid_debug_low_seen");
    cyc(1);
    reset_reset_n = 1'b0;
    #1;
    check("rst_mid_req_n",    reqs(), 3'b111);
    check("rst_mid_busy",     busy, 1'b0);
    check("rst_mid_last_req", last_req, REQ_NONE);
    key_n[2] = 1'b1;
    cyc(2);
    check("rst_mid_hold_req_n", reqs(), 3'b111);
    check("rst_mid_stm",        hps.stm_hwevents, 28'h0);
    reset_reset_n = 1'b1;
    // hw_event_in is still high: pulse re-appears 3 cycles after release
    cyc(1); check("post_rst_stm_c1", hps.stm_hwevents, 28'h0);
    cyc(1); check("post_rst_stm_c2", hps.stm_hwevents, 28'h0);
    cyc(1); check("post_rst_stm_c3", hps.stm_hwevents, 28'h0000005);
    hw_event_in = '0;
    cyc(20);

`ifdef HPS_RST_LONG_PRESS_EN
    // Warm held 300 cycles: warm pulse, then cold escalation
    f0 = falls;
    key_n[1] = 1'b0;
    cyc(300);
    key_n[1] = 1'b1;
    check("long_warm_falls", falls[1] - f0[1], 1);
    check("long_cold_falls", falls[0] - f0[0], 1);
    check("long_last_req",   last_req, REQ_COLD);
    wait_idle("long_idle");
    cyc(20);
`endif

    check("single_req_low", overlap, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
